// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: runs one full-add slice over WIDTH cycles,
// LSB first, then presents the whole result word with a one-cycle done strobe.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Full-add slice built from two half adders on the current LSBs and carry.
  logic             ha1_sum;
  logic             ha1_carry;
  logic             slice_sum;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  // Slice arithmetic and result-word shift (sum bit enters at the MSB).
  always_comb begin
    ha1_sum   = a_q[0] ^ b_q[0];
    ha1_carry = a_q[0] & b_q[0];
    slice_sum = ha1_sum ^ carry_q;
    carry_d   = ha1_carry | (ha1_sum & carry_q);
    res_d     = res_q >> 1;
    res_d[WIDTH-1] = slice_sum;
  end

  // Sequencer: IDLE -> RUN (WIDTH cycles) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            // Publish the completed word only here so no partial sum is seen.
            sum_q   <= res_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // start is deliberately not sampled here; requester must reassert.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
    .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;   // {cout, sum}
  } vec_t;

  // One full WIDTH=8 operation with latency/busy/result checks.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp, input string nm);
    int busy_n;
    int cyc;
    bit seen;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_n = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      if (busy8) busy_n++;
      if (done8) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    check({nm, " done_latency"}, cyc, 8);
    check({nm, " busy_cycles"}, busy_n, 8);
    check({nm, " result"}, {cout8, sum8}, exp);
    $display("op8 %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", nm, a, b, c, sum8, cout8);
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, done8, 0);
  endtask

  task automatic run_op1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(c);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w1 busy", busy1, 1);
    @(posedge clk); #1;
    check("w1 done", done1, 1);
    check("w1 result", {cout1, sum1}, exp);
    $display("op1: a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", a, b, c, sum1, cout1);
    @(posedge clk); #1;
    check("w1 done_drop", done1, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    int dones;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rexp;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[2] = '{8'hA5, 8'h5A, 1'b0, 9'h0FF};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 9'h046};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 9'h080};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 9'h100};
    vecs[8] = '{8'h0F, 8'hF1, 1'b0, 9'h100};
    vecs[9] = '{8'h3C, 8'h01, 1'b1, 9'h03E};

    rst8 = 1'b1; rst1 = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset result", {cout8, sum8}, 0);
    @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;

    // Table-driven WIDTH=8 operations
    for (int i = 0; i < 10; i++)
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, $sformatf("vec%0d", i));

    // start pulsed mid-RUN and during DONE must be ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0; dones = 0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    a8 = 8'h77; b8 = 8'h11; cin8 = 1; start8 = 1'b1;
    @(posedge clk); #1; cyc++;
    start8 = 1'b0;
    while (!done8 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("midrun done_latency", cyc, 8);
    check("midrun result", {cout8, sum8}, 9'h030);
    a8 = 8'h01; b8 = 8'h01; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1;
    check("done_start ignored busy", busy8, 0);
    start8 = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done8) dones++; end
    check("single done strobe", dones, 0);
    check("result held", {cout8, sum8}, 9'h030);
    $display("seq ignore-start: sum=%02h cout=%0d extra_dones=%0d", sum8, cout8, dones);

    // Async reset in the middle of RUN
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst8 = 1'b1;
    #1;
    check("async rst busy", busy8, 0);
    check("async rst done", done8, 0);
    check("async rst result", {cout8, sum8}, 0);
    #2 rst8 = 1'b0;
    dones = 0;
    repeat (12) begin @(posedge clk); #1; if (done8 || busy8) dones++; end
    check("no activity after rst", dones, 0);
    $display("seq async-reset: busy=%0d done=%0d sum=%02h", busy8, done8, sum8);
    run_op8(8'hC3, 8'h3D, 1'b0, 9'h100, "post_rst");

    // WIDTH=1: all eight input combinations
    for (int i = 0; i < 8; i++)
      run_op1(i[2], i[1], i[0]);

    // Start held continuously: one op every WIDTH+2 cycles
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      check("stream busy", busy8, 1);
      rexp = 9'(ra) + 9'(rb) + 9'(rc);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc;
      repeat (8) @(posedge clk);
      #1;
      check("stream done", done8, 1);
      check("stream result", {cout8, sum8}, 32'(rexp));
      $display("stream op %0d: sum=%02h cout=%0d exp=%03h", k, sum8, cout8, rexp);
      @(posedge clk); #1;
      check("stream idle", busy8 | done8, 0);
    end
    start8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
